// File: rtl/izhikevich_driver_if.sv
// Spike timestamp stream from the driver FIFO to the host (first-word-fall-through).
interface izhikevich_driver_if #(parameter int STEP_W = 16);
  logic              valid;
  logic              ready;
  logic [STEP_W-1:0] data;

  modport master (output valid, data, input ready);
  modport slave  (input valid, data, output ready);
endinterface

// File: rtl/izhikevich_driver.sv
// Step sequencer and spike timestamp collector for one Izhikevich neuron core.
// Build option IZH_DRIVER_STALL_EN: back-pressure a full FIFO instead of dropping spikes.
module izhikevich_driver #(
  parameter int N          = 18,
  parameter int Q          = 8,
  parameter int STEP_W     = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [STEP_W-1:0] num_steps,
  input  logic [N-1:0]      i_base,
  input  logic [N-1:0]      i_amp,
  input  logic [STEP_W-1:0] pulse_on,
  input  logic [STEP_W-1:0] pulse_off,
  output logic              core_rst,
  output logic              core_apply,
  output logic [N-1:0]      core_i,
  input  logic              core_is_spiking,
  izhikevich_driver_if.master ts,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] spike_count,
  output logic              overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);
  localparam logic [AW:0]       PTR_ONE  = (AW+1)'(1);

  if (Q >= N || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("izhikevich_driver: bad Q/N or FIFO_DEPTH");
  end

  typedef enum logic [2:0] {IDLE, INIT, APPLY, SAMPLE, DONE} state_t;

  typedef struct packed {
    logic [STEP_W-1:0] num_steps;
    logic [N-1:0]      i_base;
    logic [N-1:0]      i_amp;
    logic [STEP_W-1:0] pulse_on;
    logic [STEP_W-1:0] pulse_off;
  } cfg_t;

  state_t            state, state_nxt;
  cfg_t              cfg;
  logic [STEP_W-1:0] step, step_nxt;
  logic [STEP_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wp, rp;
  logic              full, empty, pop, spike, push, drop, stall, stalled, count_inc;
  logic [N-1:0]      i_nxt;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop   = !empty && ts.ready;

  assign ts.valid = !empty;
  assign ts.data  = empty ? '0 : mem[rp[AW-1:0]];

  // A stalled SAMPLE keeps re-offering the spike it already saw.
  assign spike = (state == SAMPLE) && (stalled || core_is_spiking);

`ifdef IZH_DRIVER_STALL_EN
  assign stall = spike && full && !pop;
  assign push  = spike && !stall;
  assign drop  = 1'b0;
`else
  assign stall = 1'b0;
  assign push  = spike && (!full || pop);
  assign drop  = spike && full && !pop;
`endif
  assign count_inc = push || drop;

  assign core_rst   = rst || (state == INIT);
  assign core_apply = (state == APPLY);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  // Window test is on the step about to be applied; empty when off <= on.
  assign i_nxt = (step_nxt >= cfg.pulse_on && step_nxt < cfg.pulse_off) ? cfg.i_amp : cfg.i_base;

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    case (state)
      IDLE:   if (start) state_nxt = INIT;
      INIT: begin
        step_nxt  = '0;
        state_nxt = (cfg.num_steps == '0) ? DONE : APPLY;
      end
      APPLY:  state_nxt = SAMPLE;
      SAMPLE: if (!stall) begin
        step_nxt  = step + STEP_ONE;
        state_nxt = (step == cfg.num_steps - STEP_ONE) ? DONE : APPLY;
      end
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      step        <= '0;
      cfg         <= '0;
      core_i      <= '0;
      stalled     <= 1'b0;
      wp          <= '0;
      rp          <= '0;
      spike_count <= '0;
      overflow    <= 1'b0;
    end else begin
      state   <= state_nxt;
      step    <= step_nxt;
      stalled <= stall;
      if (state == IDLE && start) begin
        cfg <= '{num_steps: num_steps, i_base: i_base, i_amp: i_amp,
                 pulse_on: pulse_on, pulse_off: pulse_off};
        spike_count <= '0;
        overflow    <= 1'b0;
      end else begin
        if (count_inc && !(&spike_count)) spike_count <= spike_count + STEP_ONE;
        if (drop) overflow <= 1'b1;
      end
      if (state_nxt == APPLY) core_i <= i_nxt;
      if (push) wp <= wp + PTR_ONE;
      if (pop)  rp <= rp + PTR_ONE;
    end
  end

  // Push into a full FIFO with a concurrent pop overwrites the slot being popped.
  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= step;
  end
endmodule

// File: tb/tb_izhikevich_driver.sv
// Directed bench for izhikevich_driver: model neuron core plus timestamp scoreboard.
module tb_izhikevich_driver;
  localparam int N = 18;
  localparam int STEP_W = 16;

  logic              clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [STEP_W-1:0] num_steps = '0, pulse_on = '0, pulse_off = '0;
  logic [N-1:0]      i_base = '0, i_amp = '0;
  logic              core_rst, core_apply, core_is_spiking, busy, done, overflow;
  logic [N-1:0]      core_i;
  logic [STEP_W-1:0] spike_count;

  izhikevich_driver_if #(.STEP_W(STEP_W)) ts_if();

  izhikevich_driver #(.N(N), .Q(8), .STEP_W(STEP_W), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .num_steps(num_steps),
    .i_base(i_base), .i_amp(i_amp), .pulse_on(pulse_on), .pulse_off(pulse_off),
    .core_rst(core_rst), .core_apply(core_apply), .core_i(core_i),
    .core_is_spiking(core_is_spiking), .ts(ts_if.master),
    .busy(busy), .done(done), .spike_count(spike_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Neuron core model: spike flag registered on the apply edge from a per-step mask.
  int          apply_cnt = 0;
  logic [31:0] mask = '0;
  logic        spk = 1'b0;
  assign core_is_spiking = spk;
  always @(posedge clk) begin
    if (core_rst) begin
      apply_cnt <= 0;
      spk       <= 1'b0;
    end else if (core_apply) begin
      spk       <= mask[apply_cnt];
      apply_cnt <= apply_cnt + 1;
    end
  end

  int nvec = 0, nerr = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  logic [N-1:0] exp_i [16];
  logic         chk_gap = 1'b0;
  int           last_apply = 0, done_cnt = 0;
  int           q[$];

  initial begin
    int e;
    forever begin
      @(negedge clk);
      #1;
      if (done) done_cnt++;
      if (core_apply && !rst) begin
        chk("core_i", core_i, exp_i[apply_cnt]);
        if (chk_gap && apply_cnt > 0) chk("apply_gap", cyc - last_apply, 2);
        last_apply = cyc;
      end
      if (ts_if.valid && ts_if.ready) begin
        if (q.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL ts_extra: got %0d expected none", ts_if.data);
        end else begin
          e = q.pop_front();
          chk("ts_data", ts_if.data, e);
        end
      end
    end
  end

  task automatic run(input int n, input logic [N-1:0] b, input logic [N-1:0] a,
                     input int on, input int off, output int k);
    @(negedge clk);
    num_steps = n; i_base = b; i_amp = a; pulse_on = on; pulse_off = off;
    start = 1'b1; k = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim, output int dc);
    dc = -1;
    for (int i = 0; i < lim && dc < 0; i++) begin
      if (done) dc = cyc;
      else @(negedge clk);
    end
  endtask

  task automatic drain(input int lim);
    for (int i = 0; i < lim && (q.size() != 0 || ts_if.valid); i++) @(negedge clk);
    chk("sb_empty", q.size(), 0);
    chk("fifo_empty", ts_if.valid, 1'b0);
  endtask

  task automatic set_exp(input logic [N-1:0] v);
    for (int i = 0; i < 16; i++) exp_i[i] = v;
  endtask

  initial begin
    int k, dc, d0;
    bit found;
    ts_if.ready = 1'b0;
    set_exp('0);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_core_rst", core_rst, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_apply", core_apply, 1'b0);
    chk("rst_core_i", core_i, 0);
    chk("rst_ts_valid", ts_if.valid, 1'b0);
    chk("rst_ts_data", ts_if.data, 0);
    chk("rst_done", done, 1'b0);
    chk("rst_spike_count", spike_count, 0);
    chk("rst_overflow", overflow, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("core_rst_low", core_rst, 1'b0);

    // Zero-step run
    run(0, 0, 0, 0, 0, k);
    chk("z_init_core_rst", core_rst, 1'b1);
    chk("z_init_busy", busy, 1'b1);
    chk("z_init_apply", core_apply, 1'b0);
    wait_done(20, dc);
    chk("z_done_cyc", dc, k + 2);
    chk("z_core_rst_done", core_rst, 1'b0);
    @(negedge clk);
    chk("z_busy_low", busy, 1'b0);
    chk("z_done_low", done, 1'b0);
    chk("z_applies", apply_cnt, 0);
    chk("z_fifo", ts_if.valid, 1'b0);

    // Five steps with a pulse window on steps 1..2, spikes on steps 2 and 4
    set_exp('0); exp_i[1] = 18'h0A00; exp_i[2] = 18'h0A00;
    mask = 32'h14; q.push_back(2); q.push_back(4);
    ts_if.ready = 1'b1; chk_gap = 1'b1;
    run(5, 0, 18'h0A00, 1, 3, k);
    wait_done(40, dc);
    chk("p_done_cyc", dc, k + 12);
    @(negedge clk);
    chk("p_busy_low", busy, 1'b0);
    chk("p_applies", apply_cnt, 5);
    chk("p_spike_count", spike_count, 2);
    drain(10);

    // Spikes on all 12 steps into an 8-deep FIFO with the host stalled; empty window
    set_exp(18'h123); mask = 32'hFFF; chk_gap = 1'b0; ts_if.ready = 1'b0;
    for (int i = 0; i < 8; i++) q.push_back(i);
    d0 = done_cnt;
    run(12, 18'h123, 18'h3FF, 5, 5, k);
`ifdef IZH_DRIVER_STALL_EN
    for (int i = 8; i < 12; i++) q.push_back(i);
    repeat (40) @(negedge clk);
    chk("s_busy_stalled", busy, 1'b1);
    chk("s_applies_stalled", apply_cnt, 9);
    chk("s_no_done", done_cnt - d0, 0);
    chk("s_count_stalled", spike_count, 8);
    chk("s_overflow_stalled", overflow, 1'b0);
    ts_if.ready = 1'b1;
    wait_done(200, dc);
    chk("s_done_seen", (dc >= 0) ? 1 : 0, 1);
    @(negedge clk);
    drain(40);
    chk("s_overflow", overflow, 1'b0);
    chk("s_spike_count", spike_count, 12);
`else
    wait_done(60, dc);
    chk("o_done_cyc", dc, k + 26);
    @(negedge clk);
    chk("o_overflow", overflow, 1'b1);
    chk("o_spike_count", spike_count, 12);
    chk("o_fifo_full_valid", ts_if.valid, 1'b1);
    ts_if.ready = 1'b1;
    drain(40);
`endif

    // Reset in the middle of a ten-step run
    ts_if.ready = 1'b0; set_exp('0); mask = 32'h2;
    run(10, 0, 0, 0, 0, k);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (core_apply && apply_cnt == 3) found = 1;
      else @(negedge clk);
    end
    chk("r_step3_reached", found, 1'b1);
    rst = 1'b1; d0 = done_cnt;
    @(negedge clk);
    chk("r_core_rst", core_rst, 1'b1);
    chk("r_busy", busy, 1'b0);
    chk("r_ts_valid", ts_if.valid, 1'b0);
    chk("r_done", done, 1'b0);
    chk("r_overflow", overflow, 1'b0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("r_no_done", done_cnt - d0, 0);
    chk("r_idle", busy, 1'b0);

    set_exp(18'h55); mask = 32'h1; q.push_back(0);
    ts_if.ready = 1'b1; chk_gap = 1'b1;
    run(3, 18'h55, 0, 0, 0, k);
    wait_done(30, dc);
    chk("r2_done_cyc", dc, k + 8);
    @(negedge clk);
    chk("r2_spike_count", spike_count, 1);
    chk("r2_applies", apply_cnt, 3);
    drain(10);

    // Start re-pulsed mid-run with new inputs: must be ignored
    set_exp(18'h10); exp_i[0] = 18'h20; exp_i[1] = 18'h20;
    mask = 32'hA; q.push_back(1); q.push_back(3);
    d0 = done_cnt;
    run(4, 18'h10, 18'h20, 0, 2, k);
    repeat (2) @(negedge clk);
    num_steps = 9; i_amp = 18'h3; i_base = 18'h7; pulse_off = 9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(40, dc);
    chk("m_done_cyc", dc, k + 10);
    @(negedge clk);
    chk("m_spike_count", spike_count, 2);
    chk("m_applies", apply_cnt, 4);
    repeat (10) @(negedge clk);
    chk("m_idle", busy, 1'b0);
    chk("m_one_done", done_cnt - d0, 1);
    drain(10);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/izhikevich_driver.md
# izhikevich_driver

Step sequencer and spike collector for one Izhikevich neuron core. It resets the core, then issues one `apply` pulse per simulation step for a programmed number of steps. Each step it drives a piecewise-constant stimulus current and samples the core's `is_spiking` flag. It timestamps every spike into a small FIFO that a host drains over a valid/ready stream.

## Interface
Parameters:
- `N`, 18: fixed-point word width, matching the neuron core.
- `Q`, 8: fractional bits. Pass-through only; the driver does no arithmetic on current values.
- `STEP_W`, 16: width of the step counter and of the timestamps.
- `FIFO_DEPTH`, 8: number of timestamp FIFO entries. Must be a power of two, ≥2.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a run. Sampled only in IDLE.
- `num_steps` in STEP_W: number of steps to run. Latched on `start`.
- `i_base` in N: background current. Latched on `start`.
- `i_amp` in N: current during the pulse window. Latched on `start`.
- `pulse_on` in STEP_W: first step of the pulse window, inclusive. Latched on `start`.
- `pulse_off` in STEP_W: end of the pulse window, exclusive. Latched on `start`.
- `core_rst` out 1: reset to the neuron core.
- `core_apply` out 1: step strobe to the neuron core.
- `core_i` out N: input current to the neuron core.
- `core_is_spiking` in 1: spike flag from the neuron core.
- `ts_valid` out 1: the FIFO head is valid.
- `ts_ready` in 1: the host accepts the head.
- `ts_data` out STEP_W: step index of the spike at the FIFO head.
- `busy` out 1: a run is in progress.
- `done` out 1: one-cycle pulse at the end of a run.
- `spike_count` out STEP_W: spikes in the current or last run. Saturates at all-ones.
- `overflow` out 1: sticky flag, set when a spike is dropped. Cleared on `start` or `rst`.

## Operation
- FSM states and transitions:
  - IDLE → INIT on `start`.
  - INIT → APPLY when `num_steps`≠0.
  - INIT → DONE when `num_steps`=0.
  - APPLY → SAMPLE.
  - SAMPLE → APPLY when `step` < `num_steps`−1.
  - SAMPLE → DONE on the last step.
  - DONE → IDLE.
- `core_rst` = `rst` OR (state==INIT).
- `core_apply` = (state==APPLY).
- `core_i` is registered:
  - `i_amp` when `pulse_on` ≤ `step` < `pulse_off`, otherwise `i_base`.
  - Updated on entry to APPLY, so it is stable for the entire apply cycle.
  - If `pulse_off` ≤ `pulse_on`, the window is empty and `core_i` is always `i_base`.
- SAMPLE reads `core_is_spiking`. The core registers this flag on the apply edge, so it belongs to the current `step`.
  - If 1: push `step` into the FIFO and increment `spike_count`.
- `step` is reset to 0 in INIT and increments on leaving SAMPLE.
- FIFO behaviour:
  - First-word-fall-through: `ts_valid` = not empty, `ts_data` = head.
  - A pop occurs when `ts_valid` & `ts_ready`.
  - A push into a full FIFO is permitted in the same cycle as a pop. Occupancy is unchanged.
- Ignored events:
  - `start` while `busy` is ignored.
  - Latched parameters are not affected by input changes during a run.
- `rst` mid-run:
  - State returns to IDLE next cycle and `core_rst` is asserted that cycle.
  - The FIFO is flushed, and `busy`, `done` and `overflow` clear.
  - No `done` pulse is produced.
- Reset values of registered outputs: `core_apply` 0, `core_i` 0, `ts_valid` 0, `ts_data` 0, `busy` 0, `done` 0, `spike_count` 0, `overflow` 0. `core_rst` is 1 during reset.

## Timing
- With `start` accepted at edge k:
  - `busy` rises and INIT (`core_rst`=1) occupies cycle k+1.
  - APPLY for step n occupies cycle k+2+2n; SAMPLE for step n occupies cycle k+3+2n.
- Without stalls:
  - A step takes 2 cycles.
  - `done` is high in cycle k+2+2·`num_steps`; `busy` falls after it.
  - For `num_steps`=0, `done` is high in cycle k+2.
- A spike sampled in SAMPLE appears on `ts_valid`/`ts_data` the next cycle.
- `spike_count` updates the cycle after SAMPLE.
- `done` and `busy` are never high simultaneously with IDLE.

## Configuration
- `IZH_DRIVER_STALL_EN`:
  - Defined: SAMPLE with a spike and a full FIFO (and no concurrent pop) holds state and `step`, and re-samples the latched spike each cycle until space frees. No spike is ever lost, and `overflow` stays 0. `core_apply` is not issued during the stall.
  - Undefined: the spike is dropped, `overflow` is set, `spike_count` still increments, and the FSM proceeds without delay.

## Test plan
- `num_steps`=0, `start` pulse → `core_rst` high 1 cycle, no `core_apply`, `done` 2 cycles after `start`, FIFO empty.
- `num_steps`=5, `pulse_on`=1, `pulse_off`=3, `i_base`=0, `i_amp`=0x0A00 → exactly 5 `core_apply` pulses spaced 2 cycles apart; `core_i`=0x0A00 only on steps 1 and 2.
- Model core spikes on steps 2 and 4, `ts_ready`=1 → `ts_data` 2 then 4, `spike_count`=2, `done` at cycle k+12.
- `FIFO_DEPTH`=8, spikes on all 12 steps, `ts_ready`=0:
  - With `IZH_DRIVER_STALL_EN`: run stalls at step 8 until `ts_ready`, then drains 0..11 in order, `overflow`=0.
  - Without it: entries 0..7 retained, `overflow`=1, `spike_count`=12.
- `rst` asserted at step 3 of a 10-step run → next cycle IDLE, `busy`=0, `ts_valid`=0, no `done`. A new `start` then runs normally from step 0.
- `start` re-pulsed mid-run → ignored. Run length and timestamps are unchanged.
